int_isq_dispatch: RTL and testbench
===================================

INT_ISQ_DISPATCH -- requirements
Module: int_isq_dispatch

Interface
REQ-001 SHALL have parameters (codebase macros): ISQ_DATA_WIDTH, ISQ_CONDITION_WIDTH = 2, INSTR_ID_WIDTH, PREG_RANGE = 5:0 (64 physical regs).
REQ-002 SHALL have these ports:
clock  in  1  sole clock, rising edge
reset_n  in  1  async active-low reset
in_valid  in  1  renamed int instr offered
in_ready  out  1  instr accepted when in_valid && in_ready
in_data  in  ISQ_DATA_WIDTH  issue payload; prs1 = [116:111], prs2 = [110:105]
in_robid  in  INSTR_ID_WIDTH+1  rob id incl. wrap bit
in_prd_alloc  in  1  instr writes a preg
in_prd  in  6  destination preg
enq_valid  out  1  to ISQ enqueue
enq_ready  in  1  ISQ accepts
enq_data  out  ISQ_DATA_WIDTH  held payload
enq_condition  out  2  bit1 = prs1 ready, bit0 = prs2 ready
writeback0_valid / writeback0_need_to_wb / writeback0_prd  in  1/1/6  wakeup port 0
writeback1_valid / writeback1_need_to_wb / writeback1_prd  in  1/1/6  wakeup port 1
walk_valid  in  1  ROB walk frees a squashed producer
walk_prd  in  6  preg to mark ready
rob_state  in  2  2'b00 = idle; else flushing/walking
flush_valid  in  1  flush pulse
flush_robid  in  INSTR_ID_WIDTH+1  flushing instr id

Function
REQ-003 SHALL keep a 64-bit busy table; busy[p] = 1 means preg p is not yet written back; busy[0] always reads 0.
REQ-004 SHALL keep one output holding register (valid, data, robid, condition) driving enq_*; enq_valid = held valid.
REQ-005 SHALL drive in_ready = (rob_state == 2'b00) && !flush_valid && (!enq_valid || enq_ready), combinationally.
REQ-006 On accept, SHALL load the holding register next edge; condition bit for each source = (src == 0) || !busy[src] (pre-update value) || same-cycle match on either writeback port (valid && need_to_wb && prd == src).
REQ-007 On accept with in_prd_alloc && in_prd != 0, SHALL set busy[in_prd] next edge; own-destination set SHALL NOT affect own source lookup.
REQ-008 Writeback port k with valid && need_to_wb SHALL clear busy[prd] next edge; walk_valid SHALL clear busy[walk_prd] next edge.
REQ-009 Same-cycle set and clear of one preg: set wins.
REQ-010 While held valid and not dequeued, SHALL OR each cycle's writeback matches into held condition bits (no lost wakeup during stall).
REQ-011 Dequeue (enq_valid && enq_ready) without accept SHALL clear held valid; with accept SHALL load the new instr (back-to-back, 1 instr/cycle).
REQ-012 flush_valid SHALL invalidate the held entry next edge iff held robid is younger than flush_robid: same wrap bit -> held idx > flush idx; different wrap -> held idx < flush idx; equal robid kept.
REQ-013 Flush SHALL NOT alter the busy table; squashed producers are released only via walk_valid.
REQ-014 Latency: in_valid accepted at cycle N -> enq_valid at N+1.
REQ-015 enq_data/enq_condition SHALL remain stable while enq_valid && !enq_ready, except condition bits rising per REQ-010.

Reset
REQ-016 reset_n low SHALL asynchronously clear held valid, condition, and all busy bits; enq_valid = 0, in_ready = 1 once reset_n high with rob_state idle; data/robid don't-care.
REQ-017 Reset mid-stall SHALL discard the held instr without enq_valid glitch after deassertion.

Verification
REQ-018 Reset, accept prd=5 alloc, then instr prs1=5 prs2=0 -> enq_condition = 2'b01; then writeback0 prd=5 during stall -> condition becomes 2'b11 next cycle.
REQ-019 Instr prs1=7 (busy) with writeback1 prd=7 same cycle -> enq_condition bit1 = 1 at N+1; busy[7] = 0.
REQ-020 enq_ready = 0 for 3 cycles -> in_ready = 0, enq_data held; enq_ready = 1 with in_valid -> new instr next cycle, no bubble.
REQ-021 Held robid = {1,3}, flush_robid = {0,10} -> entry dropped; held {0,3}, flush {0,10} -> kept; held == flush -> kept.
REQ-022 Alloc prd=9 and writeback0 prd=9 same cycle -> busy[9] = 1; walk_valid prd=9 -> busy[9] = 0; rob_state = 2'b01 -> in_ready = 0.

Source files
------------

// File: rtl/int_isq_dispatch_if.sv
// Dispatch-to-ISQ bundle for the integer issue queue dispatch stage.
// Carries the rename-side offer (in_*), the ISQ enqueue side (enq_*),
// the two writeback wakeup ports, the ROB walk release port, ROB state
// and the flush pulse.
//   slave  : the dispatch stage (int_isq_dispatch)
//   master : the environment driving rename, writeback, ROB and ISQ ready
interface int_isq_dispatch_if #(
   parameter int ISQ_DATA_WIDTH      = 128,
   parameter int ISQ_CONDITION_WIDTH = 2,
   parameter int INSTR_ID_WIDTH      = 5
);
   logic                           in_valid;
   logic                           in_ready;
   logic [ISQ_DATA_WIDTH-1:0]      in_data;
   logic [INSTR_ID_WIDTH:0]        in_robid;
   logic                           in_prd_alloc;
   logic [5:0]                     in_prd;
   logic                           enq_valid;
   logic                           enq_ready;
   logic [ISQ_DATA_WIDTH-1:0]      enq_data;
   logic [ISQ_CONDITION_WIDTH-1:0] enq_condition;
   logic                           writeback0_valid;
   logic                           writeback0_need_to_wb;
   logic [5:0]                     writeback0_prd;
   logic                           writeback1_valid;
   logic                           writeback1_need_to_wb;
   logic [5:0]                     writeback1_prd;
   logic                           walk_valid;
   logic [5:0]                     walk_prd;
   logic [1:0]                     rob_state;
   logic                           flush_valid;
   logic [INSTR_ID_WIDTH:0]        flush_robid;

   modport slave (
      input  in_valid, in_data, in_robid, in_prd_alloc, in_prd,
      output in_ready,
      output enq_valid, enq_data, enq_condition,
      input  enq_ready,
      input  writeback0_valid, writeback0_need_to_wb, writeback0_prd,
      input  writeback1_valid, writeback1_need_to_wb, writeback1_prd,
      input  walk_valid, walk_prd, rob_state, flush_valid, flush_robid
   );

   modport master (
      output in_valid, in_data, in_robid, in_prd_alloc, in_prd,
      input  in_ready,
      input  enq_valid, enq_data, enq_condition,
      output enq_ready,
      output writeback0_valid, writeback0_need_to_wb, writeback0_prd,
      output writeback1_valid, writeback1_need_to_wb, writeback1_prd,
      output walk_valid, walk_prd, rob_state, flush_valid, flush_robid
   );
endinterface

// File: rtl/int_isq_dispatch.sv
// Integer issue-queue dispatch stage.
// Tracks a 64-entry physical-register busy table, computes per-source
// readiness for each accepted renamed instruction and holds it in a single
// output register feeding the ISQ enqueue port. Wakeups arriving while the
// entry stalls are folded into its condition bits; a flush drops the held
// entry when it is younger than the flushing instruction.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : int_isq_dispatch_if.slave (rename offer, enqueue, wakeup,
//             walk, ROB state, flush)
module int_isq_dispatch #(
   parameter int ISQ_DATA_WIDTH      = 128,
   parameter int ISQ_CONDITION_WIDTH = 2,
   parameter int INSTR_ID_WIDTH      = 5
) (
   input logic               clock,
   input logic               reset_n,
   int_isq_dispatch_if.slave bus
);
   localparam int NPREG = 64;

   logic [NPREG-1:0]               busy_p0;
   logic [NPREG-1:0]               busy_nxt;
   logic                           vld_p1;
   logic [ISQ_DATA_WIDTH-1:0]      data_p1;
   logic [INSTR_ID_WIDTH:0]        robid_p1;
   logic [ISQ_CONDITION_WIDTH-1:0] cond_p1;
   logic [ISQ_CONDITION_WIDTH-1:0] in_cond;
   logic [ISQ_CONDITION_WIDTH-1:0] wake_cond;
   logic [5:0]                     in_prs1, in_prs2, held_prs1, held_prs2;
   logic                           wb0_en, wb1_en;
   logic                           ready, accept, deq, flush_kill;

   // Same-cycle writeback match for a source register.
   function automatic logic wb_match(input logic [5:0] src,
                                     input logic en0, input logic [5:0] prd0,
                                     input logic en1, input logic [5:0] prd1);
      return (en0 && (prd0 == src)) || (en1 && (prd1 == src));
   endfunction

   // True when held is younger (later in program order) than flush.
   // A differing wrap bit means the index order is inverted.
   function automatic logic is_younger(input logic [INSTR_ID_WIDTH:0] held,
                                       input logic [INSTR_ID_WIDTH:0] flush);
      if (held[INSTR_ID_WIDTH] == flush[INSTR_ID_WIDTH])
         return held[INSTR_ID_WIDTH-1:0] > flush[INSTR_ID_WIDTH-1:0];
      else
         return held[INSTR_ID_WIDTH-1:0] < flush[INSTR_ID_WIDTH-1:0];
   endfunction

   assign wb0_en    = bus.writeback0_valid && bus.writeback0_need_to_wb;
   assign wb1_en    = bus.writeback1_valid && bus.writeback1_need_to_wb;
   assign in_prs1   = bus.in_data[116:111];
   assign in_prs2   = bus.in_data[110:105];
   assign held_prs1 = data_p1[116:111];
   assign held_prs2 = data_p1[110:105];

   assign ready      = (bus.rob_state == 2'b00) && !bus.flush_valid &&
                       (!vld_p1 || bus.enq_ready);
   assign accept     = bus.in_valid && ready;
   assign deq        = vld_p1 && bus.enq_ready;
   assign flush_kill = bus.flush_valid && vld_p1 &&
                       is_younger(robid_p1, bus.flush_robid);

   // Readiness uses the busy value before this cycle's updates, so an
   // instruction's own destination allocation never blocks its sources.
   always_comb begin
      in_cond    = '0;
      in_cond[1] = (in_prs1 == 6'd0) || !busy_p0[in_prs1] ||
                   wb_match(in_prs1, wb0_en, bus.writeback0_prd,
                            wb1_en, bus.writeback1_prd);
      in_cond[0] = (in_prs2 == 6'd0) || !busy_p0[in_prs2] ||
                   wb_match(in_prs2, wb0_en, bus.writeback0_prd,
                            wb1_en, bus.writeback1_prd);
      wake_cond    = '0;
      wake_cond[1] = wb_match(held_prs1, wb0_en, bus.writeback0_prd,
                              wb1_en, bus.writeback1_prd);
      wake_cond[0] = wb_match(held_prs2, wb0_en, bus.writeback0_prd,
                              wb1_en, bus.writeback1_prd);
   end

   // Clears first, then the allocation set, so a same-cycle set wins.
   always_comb begin
      busy_nxt = busy_p0;
      if (wb0_en)         busy_nxt[bus.writeback0_prd] = 1'b0;
      if (wb1_en)         busy_nxt[bus.writeback1_prd] = 1'b0;
      if (bus.walk_valid) busy_nxt[bus.walk_prd]       = 1'b0;
      if (accept && bus.in_prd_alloc && (bus.in_prd != 6'd0))
         busy_nxt[bus.in_prd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // ---- stage p0 -> p1: busy table and held entry control ----
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_p0 <= '0;
         vld_p1  <= 1'b0;
         cond_p1 <= '0;
      end else begin
         busy_p0 <= busy_nxt;
         if (accept) begin
            vld_p1  <= 1'b1;
            cond_p1 <= in_cond;
         end else if (deq || flush_kill) begin
            vld_p1  <= 1'b0;
         end else if (vld_p1) begin
            cond_p1 <= cond_p1 | wake_cond;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         data_p1  <= bus.in_data;
         robid_p1 <= bus.in_robid;
      end
   end

   assign bus.in_ready      = ready;
   assign bus.enq_valid     = vld_p1;
   assign bus.enq_data      = data_p1;
   assign bus.enq_condition = cond_p1;
endmodule

// File: tb/tb_int_isq_dispatch.sv
module tb_int_isq_dispatch;
   localparam int DW  = 128;
   localparam int IDW = 5;

   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    cond;
   } exp_t;

   logic clock;
   logic reset_n;
   int   checks;
   int   errors;
   exp_t sb[$];
   exp_t mon_e;

   int_isq_dispatch_if #(.ISQ_DATA_WIDTH(DW), .ISQ_CONDITION_WIDTH(2),
                         .INSTR_ID_WIDTH(IDW)) bus ();

   int_isq_dispatch #(.ISQ_DATA_WIDTH(DW), .ISQ_CONDITION_WIDTH(2),
                      .INSTR_ID_WIDTH(IDW)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: every dequeue handshake pops one expectation.
   always @(negedge clock) begin
      if (reset_n && bus.enq_valid && bus.enq_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_deq got data=%h cond=%b want none",
                     bus.enq_data, bus.enq_condition);
         end else begin
            mon_e = sb.pop_front();
            if (bus.enq_data !== mon_e.data || bus.enq_condition !== mon_e.cond) begin
               errors++;
               $display("FAIL sb_deq got data=%h cond=%b want data=%h cond=%b",
                        bus.enq_data, bus.enq_condition, mon_e.data, mon_e.cond);
            end
         end
      end
   end

   function automatic logic [DW-1:0] mk(input logic [5:0] p1, input logic [5:0] p2,
                                        input logic [7:0] tag);
      logic [DW-1:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      d[116:111] = p1;
      d[110:105] = p2;
      d[7:0]     = tag;
      return d;
   endfunction

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.in_valid              = 1'b0;
      bus.in_prd_alloc          = 1'b0;
      bus.in_prd                = 6'd0;
      bus.writeback0_valid      = 1'b0;
      bus.writeback0_need_to_wb = 1'b0;
      bus.writeback0_prd        = 6'd0;
      bus.writeback1_valid      = 1'b0;
      bus.writeback1_need_to_wb = 1'b0;
      bus.writeback1_prd        = 6'd0;
      bus.walk_valid            = 1'b0;
      bus.walk_prd              = 6'd0;
      bus.rob_state             = 2'b00;
      bus.flush_valid           = 1'b0;
      bus.flush_robid           = '0;
   endtask

   task automatic offer(input logic [DW-1:0] d, input logic [IDW:0] rid,
                        input logic alloc, input logic [5:0] prd);
      bus.in_valid     = 1'b1;
      bus.in_data      = d;
      bus.in_robid     = rid;
      bus.in_prd_alloc = alloc;
      bus.in_prd       = prd;
   endtask

   task automatic test_reset();
      idle();
      bus.in_data   = '0;
      bus.in_robid  = '0;
      bus.enq_ready = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (bus.enq_valid !== 1'b0 || bus.enq_condition !== 2'b00) begin
         errors++;
         $display("FAIL reset_state got vld=%b cond=%b want 0 00",
                  bus.enq_valid, bus.enq_condition);
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
      end
      cyc();
   endtask

   task automatic test_wakeup();
      logic [DW-1:0] d1, d2;
      bus.enq_ready = 1'b1;
      d1 = mk(6'd0, 6'd0, 8'd1);
      offer(d1, 6'h01, 1'b1, 6'd5);
      sb.push_back('{d1, 2'b11});
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL wake_in_ready got %b want 1", bus.in_ready);
      end
      cyc();
      checks++;
      if (bus.enq_valid !== 1'b1 || bus.enq_condition !== 2'b11) begin
         errors++;
         $display("FAIL wake_latency got vld=%b cond=%b want 1 11",
                  bus.enq_valid, bus.enq_condition);
      end
      d2 = mk(6'd5, 6'd0, 8'd2);
      offer(d2, 6'h02, 1'b0, 6'd0);
      sb.push_back('{d2, 2'b11});
      cyc();
      checks++;
      if (bus.enq_valid !== 1'b1 || bus.enq_condition !== 2'b01 || bus.enq_data !== d2) begin
         errors++;
         $display("FAIL wake_busy_src got vld=%b cond=%b want 1 01",
                  bus.enq_valid, bus.enq_condition);
      end
      idle();
      bus.enq_ready = 1'b0;
      bus.writeback0_valid      = 1'b1;
      bus.writeback0_need_to_wb = 1'b1;
      bus.writeback0_prd        = 6'd5;
      cyc();
      idle();
      checks++;
      if (bus.enq_valid !== 1'b1 || bus.enq_condition !== 2'b11) begin
         errors++;
         $display("FAIL wake_stall_or got vld=%b cond=%b want 1 11",
                  bus.enq_valid, bus.enq_condition);
      end
      bus.enq_ready = 1'b1;
      cyc();
      checks++;
      if (bus.enq_valid !== 1'b0) begin
         errors++;
         $display("FAIL wake_drain got vld=%b want 0", bus.enq_valid);
      end
   endtask

   task automatic test_wb_bypass();
      logic [DW-1:0] d;
      bus.enq_ready = 1'b1;
      d = mk(6'd0, 6'd0, 8'd3);
      offer(d, 6'h03, 1'b1, 6'd7);
      sb.push_back('{d, 2'b11});
      cyc();
      d = mk(6'd7, 6'd7, 8'd4);
      offer(d, 6'h04, 1'b0, 6'd0);
      bus.writeback1_valid      = 1'b1;
      bus.writeback1_need_to_wb = 1'b1;
      bus.writeback1_prd        = 6'd7;
      sb.push_back('{d, 2'b11});
      cyc();
      idle();
      checks++;
      if (bus.enq_condition !== 2'b11) begin
         errors++;
         $display("FAIL bypass_wb1 got cond=%b want 11", bus.enq_condition);
      end
      d = mk(6'd7, 6'd0, 8'd5);
      offer(d, 6'h05, 1'b1, 6'd8);
      sb.push_back('{d, 2'b11});
      cyc();
      checks++;
      if (bus.enq_condition !== 2'b11) begin
         errors++;
         $display("FAIL bypass_busy7_clear got cond=%b want 11", bus.enq_condition);
      end
      d = mk(6'd8, 6'd0, 8'd6);
      offer(d, 6'h06, 1'b0, 6'd0);
      bus.writeback1_valid      = 1'b1;
      bus.writeback1_need_to_wb = 1'b0;
      bus.writeback1_prd        = 6'd8;
      sb.push_back('{d, 2'b01});
      cyc();
      idle();
      checks++;
      if (bus.enq_condition !== 2'b01) begin
         errors++;
         $display("FAIL bypass_no_need_to_wb got cond=%b want 01", bus.enq_condition);
      end
      d = mk(6'd0, 6'd8, 8'd7);
      offer(d, 6'h07, 1'b0, 6'd0);
      bus.walk_valid = 1'b1;
      bus.walk_prd   = 6'd8;
      sb.push_back('{d, 2'b10});
      cyc();
      idle();
      checks++;
      if (bus.enq_condition !== 2'b10) begin
         errors++;
         $display("FAIL bypass_walk_not_bypassed got cond=%b want 10", bus.enq_condition);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] d1, d2;
      bus.enq_ready = 1'b1;
      d1 = mk(6'd0, 6'd0, 8'd8);
      offer(d1, 6'h08, 1'b0, 6'd0);
      sb.push_back('{d1, 2'b11});
      cyc();
      bus.enq_ready = 1'b0;
      d2 = mk(6'd0, 6'd8, 8'd9);
      offer(d2, 6'h09, 1'b0, 6'd0);
      sb.push_back('{d2, 2'b11});
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready[%0d] got %b want 0", i, bus.in_ready);
         end
         cyc();
         checks++;
         if (bus.enq_valid !== 1'b1 || bus.enq_data !== d1) begin
            errors++;
            $display("FAIL stall_hold[%0d] got vld=%b data=%h want 1 %h",
                     i, bus.enq_valid, bus.enq_data, d1);
         end
      end
      bus.enq_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_in_ready got %b want 1", bus.in_ready);
      end
      cyc();
      idle();
      checks++;
      if (bus.enq_valid !== 1'b1 || bus.enq_data !== d2) begin
         errors++;
         $display("FAIL b2b_no_bubble got vld=%b data=%h want 1 %h",
                  bus.enq_valid, bus.enq_data, d2);
      end
      cyc();
   endtask

   task automatic test_flush();
      logic [IDW:0]  held_t[5]  = '{6'h23, 6'h03, 6'h0A, 6'h0C, 6'h2C};
      logic [IDW:0]  flush_t[5] = '{6'h0A, 6'h0A, 6'h0A, 6'h0A, 6'h0A};
      logic          keep_t[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [DW-1:0] d;
      for (int i = 0; i < 5; i++) begin
         bus.enq_ready = 1'b0;
         d = mk(6'd0, 6'd0, 8'(16 + i));
         offer(d, held_t[i], 1'b0, 6'd0);
         sb.push_back('{d, 2'b11});
         cyc();
         idle();
         bus.flush_valid = 1'b1;
         bus.flush_robid = flush_t[i];
         #1;
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready[%0d] got %b want 0", i, bus.in_ready);
         end
         cyc();
         idle();
         checks++;
         if (bus.enq_valid !== keep_t[i]) begin
            errors++;
            $display("FAIL flush_case[%0d] got vld=%b want %b", i, bus.enq_valid, keep_t[i]);
         end
         if (!keep_t[i]) void'(sb.pop_back());
         bus.enq_ready = 1'b1;
         cyc();
      end
   endtask

   task automatic test_busy();
      logic [DW-1:0] d;
      bus.enq_ready = 1'b1;
      d = mk(6'd0, 6'd0, 8'd32);
      offer(d, 6'h10, 1'b1, 6'd9);
      bus.writeback0_valid      = 1'b1;
      bus.writeback0_need_to_wb = 1'b1;
      bus.writeback0_prd        = 6'd9;
      sb.push_back('{d, 2'b11});
      cyc();
      idle();
      d = mk(6'd9, 6'd0, 8'd33);
      offer(d, 6'h11, 1'b0, 6'd0);
      sb.push_back('{d, 2'b01});
      cyc();
      idle();
      checks++;
      if (bus.enq_condition !== 2'b01) begin
         errors++;
         $display("FAIL busy_set_wins got cond=%b want 01", bus.enq_condition);
      end
      bus.walk_valid = 1'b1;
      bus.walk_prd   = 6'd9;
      cyc();
      idle();
      d = mk(6'd0, 6'd9, 8'd34);
      offer(d, 6'h12, 1'b0, 6'd0);
      sb.push_back('{d, 2'b11});
      cyc();
      idle();
      checks++;
      if (bus.enq_condition !== 2'b11) begin
         errors++;
         $display("FAIL busy_walk_clear got cond=%b want 11", bus.enq_condition);
      end
      d = mk(6'd10, 6'd0, 8'd35);
      offer(d, 6'h13, 1'b1, 6'd10);
      sb.push_back('{d, 2'b11});
      cyc();
      idle();
      checks++;
      if (bus.enq_condition !== 2'b11) begin
         errors++;
         $display("FAIL busy_own_dest got cond=%b want 11", bus.enq_condition);
      end
      d = mk(6'd10, 6'd10, 8'd36);
      offer(d, 6'h14, 1'b0, 6'd0);
      sb.push_back('{d, 2'b00});
      cyc();
      idle();
      checks++;
      if (bus.enq_condition !== 2'b00) begin
         errors++;
         $display("FAIL busy_both_src got cond=%b want 00", bus.enq_condition);
      end
      bus.walk_valid = 1'b1;
      bus.walk_prd   = 6'd10;
      bus.rob_state  = 2'b01;
      offer(mk(6'd0, 6'd0, 8'd37), 6'h15, 1'b0, 6'd0);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rob_walk_in_ready got %b want 0", bus.in_ready);
      end
      cyc();
      idle();
      checks++;
      if (bus.enq_valid !== 1'b0) begin
         errors++;
         $display("FAIL rob_walk_no_accept got vld=%b want 0", bus.enq_valid);
      end
   endtask

   task automatic test_reset_mid_stall();
      logic [DW-1:0] d;
      bus.enq_ready = 1'b0;
      offer(mk(6'd0, 6'd0, 8'd40), 6'h16, 1'b1, 6'd11);
      cyc();
      idle();
      checks++;
      if (bus.enq_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_stall_loaded got vld=%b want 1", bus.enq_valid);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.enq_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got vld=%b want 0", bus.enq_valid);
      end
      cyc();
      reset_n = 1'b1;
      #1;
      checks++;
      if (bus.enq_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_reset got vld=%b rdy=%b want 0 1", bus.enq_valid, bus.in_ready);
      end
      bus.enq_ready = 1'b1;
      d = mk(6'd11, 6'd0, 8'd41);
      offer(d, 6'h17, 1'b0, 6'd0);
      sb.push_back('{d, 2'b11});
      cyc();
      idle();
      checks++;
      if (bus.enq_valid !== 1'b1 || bus.enq_condition !== 2'b11) begin
         errors++;
         $display("FAIL reset_clears_busy got vld=%b cond=%b want 1 11",
                  bus.enq_valid, bus.enq_condition);
      end
      cyc();
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      test_reset();
      test_wakeup();
      test_wb_bypass();
      test_back_to_back();
      test_flush();
      test_busy();
      test_reset_mid_stall();
      repeat (2) cyc();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d entries want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
